ascon_permutation: RTL and testbench

ASCON_PERMUTATION -- requirements
Module: ascon_permutation

---
 rtl/ascon_pkg.sv | 55 +++++
 rtl/ascon_round.sv | 35 +++
 rtl/ascon_permutation.sv | 98 +++++++++
 tb/tb_ascon_permutation.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pkg.sv
// Shared Ascon definitions: word and state types, round constants, S-box and the
// linear-layer rotate amounts.
package ascon_pkg;

    typedef logic [63:0] u64_t;
    typedef logic [3:0]  rnd_t;

    // x0 occupies the most significant word, matching the flat 320-bit port order.
    typedef struct packed {
        u64_t x0;
        u64_t x1;
        u64_t x2;
        u64_t x3;
        u64_t x4;
    } ascon_state_t;

    typedef enum logic {StIdle, StRun} perm_fsm_e;

    localparam int unsigned ROUNDS_MAX = 12;

    localparam u64_t ASCON128_IV = 64'h80400c0600000000;

    localparam logic [0:11][7:0] RndConst = {
        8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
        8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
    };

    localparam logic [0:31][4:0] Sbox = {
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    localparam int unsigned Rot0A = 19;
    localparam int unsigned Rot0B = 28;
    localparam int unsigned Rot1A = 61;
    localparam int unsigned Rot1B = 39;
    localparam int unsigned Rot2A = 1;
    localparam int unsigned Rot2B = 6;
    localparam int unsigned Rot3A = 10;
    localparam int unsigned Rot3B = 17;
    localparam int unsigned Rot4A = 7;
    localparam int unsigned Rot4B = 41;

    function automatic u64_t ror64(input u64_t x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // Indices past the last round only occur on unused chain stages; they get no constant.
    function automatic logic [7:0] rnd_const(input rnd_t idx);
        return (idx < rnd_t'(ROUNDS_MAX)) ? RndConst[idx] : 8'h00;
    endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant addition, bitsliced S-box, linear diffusion.
module ascon_round
    import ascon_pkg::*;
(
    input  logic [319:0] i_state,
    input  logic [7:0]   i_rc,
    output logic [319:0] o_state
);

    ascon_state_t w_add;
    ascon_state_t w_sub;

    always_comb begin
        w_add = ascon_state_t'(i_state);
        w_add.x2[7:0] = w_add.x2[7:0] ^ i_rc;
    end

    // Each bit column {x0..x4} is one 5-bit S-box lookup, MSB in x0.
    always_comb begin
        w_sub = '0;
        for (int i = 0; i < 64; i++) begin
            {w_sub.x0[i], w_sub.x1[i], w_sub.x2[i], w_sub.x3[i], w_sub.x4[i]} =
                Sbox[{w_add.x0[i], w_add.x1[i], w_add.x2[i], w_add.x3[i], w_add.x4[i]}];
        end
    end

    assign o_state = {
        w_sub.x0 ^ ror64(w_sub.x0, Rot0A) ^ ror64(w_sub.x0, Rot0B),
        w_sub.x1 ^ ror64(w_sub.x1, Rot1A) ^ ror64(w_sub.x1, Rot1B),
        w_sub.x2 ^ ror64(w_sub.x2, Rot2A) ^ ror64(w_sub.x2, Rot2B),
        w_sub.x3 ^ ror64(w_sub.x3, Rot3A) ^ ror64(w_sub.x3, Rot3B),
        w_sub.x4 ^ ror64(w_sub.x4, Rot4A) ^ ror64(w_sub.x4, Rot4B)
    };

endmodule

// File: rtl/ascon_permutation.sv
// Iterative Ascon permutation: loads a state on start, applies ROUNDS_PER_CYCLE rounds
// per clock until round index 12, then pulses done.
module ascon_permutation
    import ascon_pkg::*;
#(
    parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic [3:0]   nb_rounds_i,
    input  logic [319:0] state_i,
    output logic [319:0] state_o,
    output logic         busy_o,
    output logic         done_o
);

    localparam rnd_t RoundStep = rnd_t'(ROUNDS_PER_CYCLE);

    perm_fsm_e    r_fsm;
    perm_fsm_e    w_fsm_d;
    ascon_state_t r_state;
    ascon_state_t w_state_d;
    rnd_t         r_idx;
    rnd_t         w_idx_d;
    rnd_t         w_idx_after;
    rnd_t         w_nb_clamped;
    logic         r_done;
    logic         w_done_d;

    ascon_state_t w_chain [ROUNDS_PER_CYCLE+1];

    assign w_chain[0] = r_state;

    for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_round
        ascon_round u_round (
            .i_state (w_chain[g]),
            .i_rc    (rnd_const(r_idx + rnd_t'(g))),
            .o_state (w_chain[g+1])
        );
    end

    // Out-of-range requests run the full 12 rounds; two-round stepping needs an even count.
    always_comb begin
        w_nb_clamped = nb_rounds_i;
        if (nb_rounds_i == '0 || nb_rounds_i > rnd_t'(ROUNDS_MAX)) begin
            w_nb_clamped = rnd_t'(ROUNDS_MAX);
        end
        if (ROUNDS_PER_CYCLE == 2 && w_nb_clamped[0]) begin
            w_nb_clamped = w_nb_clamped + 4'd1;
        end
    end

    assign w_idx_after = r_idx + RoundStep;

    always_comb begin
        w_fsm_d   = r_fsm;
        w_state_d = r_state;
        w_idx_d   = r_idx;
        w_done_d  = 1'b0;
        unique case (r_fsm)
            StIdle: begin
                if (start_i) begin
                    w_fsm_d   = StRun;
                    w_state_d = ascon_state_t'(state_i);
                    w_idx_d   = rnd_t'(ROUNDS_MAX) - w_nb_clamped;
                end
            end
            StRun: begin
                w_state_d = w_chain[ROUNDS_PER_CYCLE];
                w_idx_d   = w_idx_after;
                if (w_idx_after >= rnd_t'(ROUNDS_MAX)) begin
                    w_fsm_d  = StIdle;
                    w_done_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fsm   <= StIdle;
            r_state <= '0;
            r_idx   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_fsm   <= w_fsm_d;
            r_state <= w_state_d;
            r_idx   <= w_idx_d;
            r_done  <= w_done_d;
        end
    end

    assign state_o = r_state;
    assign busy_o  = (r_fsm == StRun);
    assign done_o  = r_done;

endmodule

// File: tb/tb_ascon_permutation.sv
// Scoreboard bench for ascon_permutation: one-round and two-round-per-cycle instances
// checked against a word-level Ascon reference model.
module tb_ascon_permutation;
    import ascon_pkg::*;

    typedef struct {
        logic [319:0] st;
        int unsigned  due;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    int unsigned  cyc = 0;

    logic         start0, start1;
    logic [3:0]   nb0, nb1;
    logic [319:0] sti0, sti1, sto0, sto1;
    logic         busy0, busy1, done0, done1;
    logic         prev_done0 = 1'b0;
    logic         prev_done1 = 1'b0;

    exp_t q0[$];
    exp_t q1[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ascon_permutation #(.ROUNDS_PER_CYCLE(1)) u_dut0 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start0),
        .nb_rounds_i (nb0),
        .state_i     (sti0),
        .state_o     (sto0),
        .busy_o      (busy0),
        .done_o      (done0)
    );

    ascon_permutation #(.ROUNDS_PER_CYCLE(2)) u_dut1 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start1),
        .nb_rounds_i (nb1),
        .state_i     (sti1),
        .state_o     (sto1),
        .busy_o      (busy1),
        .done_o      (done1)
    );

    // ---------------- reference model ----------------
    function automatic u64_t rotr(input u64_t x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [319:0] model_perm(input logic [319:0] s_in, input int n);
        u64_t x[5];
        u64_t t[5];
        for (int w = 0; w < 5; w++) x[w] = s_in[319 - 64*w -: 64];
        for (int r = 12 - n; r < 12; r++) begin
            x[2] ^= u64_t'(((15 - r) << 4) | r);
            x[0] ^= x[4];
            x[4] ^= x[3];
            x[2] ^= x[1];
            for (int w = 0; w < 5; w++) t[w] = ~x[w] & x[(w + 1) % 5];
            for (int w = 0; w < 5; w++) x[w] ^= t[(w + 1) % 5];
            x[1] ^= x[0];
            x[0] ^= x[4];
            x[3] ^= x[2];
            x[2] = ~x[2];
            x[0] = x[0] ^ rotr(x[0], 19) ^ rotr(x[0], 28);
            x[1] = x[1] ^ rotr(x[1], 61) ^ rotr(x[1], 39);
            x[2] = x[2] ^ rotr(x[2], 1)  ^ rotr(x[2], 6);
            x[3] = x[3] ^ rotr(x[3], 10) ^ rotr(x[3], 17);
            x[4] = x[4] ^ rotr(x[4], 7)  ^ rotr(x[4], 41);
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic int eff_rounds(input logic [3:0] nb, input int rpc);
        int n;
        n = (nb == 4'd0 || nb > 4'd12) ? 12 : int'(nb);
        if (rpc == 2 && (n % 2) == 1) n++;
        return n;
    endfunction

    function automatic logic [319:0] rand_state();
        logic [319:0] r;
        r = '0;
        for (int i = 0; i < 10; i++) r = {r[287:0], $urandom()};
        return r;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic monitor_one(input int k);
        logic         d;
        logic         pd;
        logic [319:0] so;
        exp_t         e;
        int           pending;
        d       = (k == 0) ? done0 : done1;
        pd      = (k == 0) ? prev_done0 : prev_done1;
        so      = (k == 0) ? sto0 : sto1;
        pending = (k == 0) ? q0.size() : q1.size();
        if (d === 1'b1) begin
            tests++;
            if (pd === 1'b1) begin
                fails++;
                $display("FAIL done_width dut%0d: done high on two cycles, expected one", k);
            end
            tests++;
            if (pending == 0) begin
                fails++;
                $display("FAIL unexpected_done dut%0d: got done=1 expected no pending op", k);
            end else begin
                if (k == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                check($sformatf("result dut%0d", k), so, e.st);
                tests++;
                if (cyc != e.due) begin
                    fails++;
                    $display("FAIL latency dut%0d: done at cycle %0d expected cycle %0d",
                             k, cyc, e.due);
                end
            end
        end
        if (k == 0) prev_done0 = d;
        else        prev_done1 = d;
    endtask

    always @(negedge clk) begin
        monitor_one(0);
        monitor_one(1);
    end

    // ---------------- stimulus ----------------
    // Called at a negedge; the following posedge samples start.
    task automatic issue(input int k, input logic [3:0] nb, input logic [319:0] st);
        exp_t e;
        int   rpc;
        int   n;
        rpc   = (k == 0) ? 1 : 2;
        n     = eff_rounds(nb, rpc);
        e.st  = model_perm(st, n);
        e.due = cyc + 1 + n / rpc;
        if (k == 0) begin
            start0 = 1'b1; nb0 = nb; sti0 = st; q0.push_back(e);
        end else begin
            start1 = 1'b1; nb1 = nb; sti1 = st; q1.push_back(e);
        end
        @(negedge clk);
        if (k == 0) start0 = 1'b0;
        else        start1 = 1'b0;
    endtask

    task automatic wait_done(input int k, input int budget);
        int i;
        i = 0;
        while (((k == 0) ? done0 : done1) !== 1'b1 && i < budget) begin
            @(negedge clk);
            i++;
        end
        tests++;
        if (((k == 0) ? done0 : done1) !== 1'b1) begin
            fails++;
            $display("FAIL timeout dut%0d: no done within %0d cycles, expected done", k, budget);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

    initial begin
        logic [319:0] s;
        rst_n = 1'b0;
        start0 = 1'b0; start1 = 1'b0;
        nb0 = '0; nb1 = '0;
        sti0 = '0; sti1 = '0;
        repeat (3) @(negedge clk);
        check("reset state0", sto0, '0);
        check("reset busy0", {319'b0, busy0}, '0);
        check("reset done0", {319'b0, done0}, '0);
        check("reset state1", sto1, '0);
        check("reset busy1", {319'b0, busy1}, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Ascon-128 initialisation
        issue(0, 4'd12, {ASCON128_IV, 256'b0});
        check("busy after start", {319'b0, busy0}, 320'd1);
        wait_done(0, 20);

        // p6 and p8 on random states
        issue(0, 4'd6, rand_state());
        wait_done(0, 20);
        issue(0, 4'd8, rand_state());
        wait_done(0, 20);

        // clamping: 0 and 15 behave as 12
        s = rand_state();
        issue(0, 4'd0, s);
        wait_done(0, 20);
        issue(0, 4'd15, s);
        wait_done(0, 20);

        // state held in idle
        repeat (4) @(negedge clk);
        check("hold idle", sto0, model_perm(s, 12));
        check("idle busy", {319'b0, busy0}, '0);

        // start while busy is ignored
        issue(0, 4'd12, rand_state());
        repeat (2) @(negedge clk);
        start0 = 1'b1; nb0 = 4'd3; sti0 = rand_state();
        @(negedge clk);
        start0 = 1'b0;
        wait_done(0, 20);
        repeat (3) @(negedge clk);

        // back-to-back with random lengths
        issue(0, 4'd6, rand_state());
        wait_done(0, 20);
        for (int i = 0; i < 6; i++) begin
            issue(0, 4'($urandom_range(0, 15)), rand_state());
            wait_done(0, 20);
        end
        repeat (2) @(negedge clk);

        // reset in the middle of a p12
        issue(0, 4'd12, rand_state());
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset state", sto0, '0);
        check("midreset busy", {319'b0, busy0}, '0);
        q0.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("after reset busy", {319'b0, busy0}, '0);
        issue(0, 4'd12, rand_state());
        wait_done(0, 20);

        // two rounds per cycle
        s = rand_state();
        issue(1, 4'd7, s);
        wait_done(1, 20);
        issue(1, 4'd8, s);
        wait_done(1, 20);
        issue(1, 4'd0, rand_state());
        wait_done(1, 20);
        for (int i = 0; i < 5; i++) begin
            issue(1, 4'($urandom_range(0, 15)), rand_state());
            wait_done(1, 20);
        end
        repeat (4) @(negedge clk);

        tests++;
        if (q0.size() + q1.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d ops still pending expected 0", q0.size() + q1.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
